// File: rtl/dpsk_mod.sv
// dpsk_mod: differential PSK modulator sitting behind the dds NCO.
// Each accepted bit is XOR-encoded against the previous symbol and selects the carrier sign for SPS valid samples.
module dpsk_mod #(
    parameter int DW  = 10,
    parameter int SPS = 32,
    parameter int CW  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 car_valid,
    input  logic signed [DW-1:0] car_sin,
    input  logic                 data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic signed [DW-1:0] mod_out,
    output logic                 mod_valid,
    output logic                 sym_strobe,
    output logic                 diff_bit,
    output logic                 underrun
);

    typedef enum logic {IDLE, RUN} state_t;

    // The counter stores (samples emitted in this symbol - 1), so SPS fits in CW bits.
    localparam logic [CW-1:0]        LAST  = CW'(SPS - 1);
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 hold_full, hold_full_n;
    logic                 hold_bit, hold_bit_n;
    logic                 d_n;
    logic                 underrun_n;
    logic                 emit;
    logic                 strobe_n;
    logic                 to_idle;
    logic                 consume;
    logic signed [DW-1:0] sample;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_full_n = hold_full;
        hold_bit_n  = hold_bit;
        d_n         = diff_bit;
        underrun_n  = underrun;
        emit        = 1'b0;
        strobe_n    = 1'b0;
        to_idle     = 1'b0;
        consume     = 1'b0;

        if (data_valid && data_ready) begin
            hold_full_n = 1'b1;
            hold_bit_n  = data_in;
        end

        if (car_valid) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        consume  = 1'b1;
                        d_n      = hold_bit ^ diff_bit;
                        state_n  = RUN;
                        cnt_n    = '0;
                        emit     = 1'b1;
                        strobe_n = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt != LAST) begin
                        emit  = 1'b1;
                        cnt_n = cnt + CW'(1);
                    end else if (hold_full) begin
                        consume  = 1'b1;
                        d_n      = hold_bit ^ diff_bit;
                        cnt_n    = '0;
                        emit     = 1'b1;
                        strobe_n = 1'b1;
                    end else begin
                        // Nothing to send at the boundary: drop back to IDLE with d_prev cleared.
                        underrun_n = 1'b1;
                        state_n    = IDLE;
                        d_n        = 1'b0;
                        cnt_n      = '0;
                        to_idle    = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (consume) begin
            hold_full_n = 1'b0;
        end
    end

    // Negating the most negative code would wrap, so it saturates to the positive rail.
    always_comb begin
        if (!d_n) begin
            sample = car_sin;
        end else if (car_sin == S_MIN) begin
            sample = S_MAX;
        end else begin
            sample = -car_sin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_full  <= 1'b0;
            hold_bit   <= 1'b0;
            data_ready <= 1'b1;
            diff_bit   <= 1'b0;
            underrun   <= 1'b0;
            mod_out    <= '0;
            mod_valid  <= 1'b0;
            sym_strobe <= 1'b0;
        end else if (clken) begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold_full  <= hold_full_n;
            hold_bit   <= hold_bit_n;
            data_ready <= !hold_full_n;
            diff_bit   <= d_n;
            underrun   <= underrun_n;
            mod_valid  <= emit;
            sym_strobe <= strobe_n;
            if (emit) begin
                mod_out <= sample;
            end else if (to_idle) begin
                mod_out <= '0;
            end
        end else begin
            mod_valid  <= 1'b0;
            sym_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dpsk_mod.sv
// tb_dpsk_mod: directed bench for dpsk_mod with hand-computed symbol sequences.
// A small reference tracks symbol count, expected sign and handshake occupancy.
module tb_dpsk_mod;

    localparam int DW  = 10;
    localparam int SPS = 32;
    localparam int CW  = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clken;
    logic                 car_valid;
    logic signed [DW-1:0] car_sin;
    logic                 data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic signed [DW-1:0] mod_out;
    logic                 mod_valid;
    logic                 sym_strobe;
    logic                 diff_bit;
    logic                 underrun;

    int total = 0;
    int bad   = 0;
    int n_valid;
    int n_strobe;
    int n_acc;
    int held;
    bit bit_q[$];
    bit exp_d[$];

    dpsk_mod #(.DW(DW), .SPS(SPS), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .car_valid  (car_valid),
        .car_sin    (car_sin),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .mod_out    (mod_out),
        .mod_valid  (mod_valid),
        .sym_strobe (sym_strobe),
        .diff_bit   (diff_bit),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int modExp(input int s, input bit d);
        if (!d) return s;
        if (s == -512) return 511;
        return -s;
    endfunction

    task automatic refreshData();
        data_valid = (bit_q.size() > 0);
        data_in    = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        clken     = 1'b1;
        car_valid = 1'b1;
        car_sin   = '0;
        bit_q.delete();
        refreshData();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mod_valid", mod_valid, 0);
        checkOutput("rst_data_ready", data_ready, 1);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_mod_out", mod_out, 0);
        checkOutput("rst_diff_bit", diff_bit, 0);
        checkOutput("rst_strobe", sym_strobe, 0);
        reset    = 1'b0;
        n_valid  = 0;
        n_strobe = 0;
        n_acc    = 0;
        exp_d.delete();
    endtask

    // One clock of stimulus, followed by the reference checks on the registered outputs.
    task automatic applyStimulus(input bit cv, input int s, input bit ce);
        bit act;
        bit fire;
        car_valid = cv;
        car_sin   = DW'(s);
        clken     = ce;
        act  = cv && ce;
        fire = data_valid && data_ready && ce;
        @(posedge clk);
        #1;
        if (fire) begin
            void'(bit_q.pop_front());
            n_acc++;
            refreshData();
        end
        if (!act) begin
            checkOutput("inactive_valid", mod_valid, 0);
            checkOutput("inactive_strobe", sym_strobe, 0);
        end
        if (mod_valid) begin
            checkOutput("strobe_pos", sym_strobe, int'((n_valid % SPS) == 0));
            if (sym_strobe) begin
                if (n_strobe < exp_d.size())
                    checkOutput("diff_bit", diff_bit, exp_d[n_strobe]);
                else
                    checkOutput("sym_count", n_strobe + 1, exp_d.size());
                n_strobe++;
            end
            if (n_strobe > 0 && n_strobe <= exp_d.size())
                checkOutput("mod_out", mod_out, modExp(s, exp_d[n_strobe-1]));
            n_valid++;
        end
        checkOutput("data_ready", data_ready, int'(n_acc == n_strobe));
    endtask

    initial begin
        reset      = 1'b1;
        clken      = 1'b1;
        car_valid  = 1'b0;
        car_sin    = '0;
        data_in    = 1'b0;
        data_valid = 1'b0;

        // Idle after reset with carrier running and no data.
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 100, 1'b1);
        checkOutput("idle_mod_valid", mod_valid, 0);
        checkOutput("idle_underrun", underrun, 0);

        // Differential encoding of 1,0,1,1,0.
        doReset();
        bit_q = '{1, 0, 1, 1, 0};
        exp_d = '{1, 1, 0, 1, 1};
        refreshData();
        for (int k = 0; k < 170; k++) applyStimulus(1'b1, ((k * 37) % 1000) - 500, 1'b1);
        checkOutput("enc_valid_count", n_valid, 160);
        checkOutput("enc_sym_count", n_strobe, 5);
        checkOutput("enc_underrun", underrun, 1);

        // Sign inversion and saturation during a d=1 symbol.
        doReset();
        bit_q = '{1};
        exp_d = '{1};
        refreshData();
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b1, 300, 1'b1);
        checkOutput("sat_pos", mod_out, -300);
        checkOutput("sat_first_strobe", sym_strobe, 1);
        applyStimulus(1'b1, -300, 1'b1);
        checkOutput("sat_neg", mod_out, 300);
        applyStimulus(1'b1, -512, 1'b1);
        checkOutput("sat_min", mod_out, 511);
        applyStimulus(1'b1, 511, 1'b1);
        checkOutput("sat_max", mod_out, -511);

        // Carrier gaps and a clken stall mid-symbol.
        doReset();
        bit_q = '{0, 1};
        exp_d = '{0, 1};
        refreshData();
        held = 0;
        for (int cyc = 0; cyc < 300 && n_valid < 64; cyc++) begin
            applyStimulus(cyc % 2 == 0, (cyc * 13) % 400 - 200, !(cyc >= 40 && cyc < 45));
            if (cyc == 39) held = mod_out;
            if (cyc == 44) checkOutput("stall_hold", mod_out, held);
        end
        checkOutput("gap_valid_count", n_valid, 64);
        checkOutput("gap_sym_count", n_strobe, 2);

        // Underrun at the boundary, then restart with d_prev cleared.
        doReset();
        bit_q = '{1};
        exp_d = '{1};
        refreshData();
        for (int cyc = 0; cyc < 40 && n_valid < 32; cyc++) applyStimulus(1'b1, 50 + cyc, 1'b1);
        checkOutput("ur_valid_count", n_valid, 32);
        checkOutput("ur_before", underrun, 0);
        applyStimulus(1'b1, 77, 1'b1);
        checkOutput("ur_flag", underrun, 1);
        checkOutput("ur_mod_valid", mod_valid, 0);
        checkOutput("ur_mod_out", mod_out, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 60, 1'b1);
            checkOutput("ur_idle_valid", mod_valid, 0);
        end
        bit_q.push_back(1'b1);
        exp_d.push_back(1'b1);
        refreshData();
        for (int cyc = 0; cyc < 10 && n_strobe < 2; cyc++) applyStimulus(1'b1, -90, 1'b1);
        checkOutput("ur_restart_sym", n_strobe, 2);
        checkOutput("ur_restart_diff", diff_bit, 1);
        checkOutput("ur_sticky", underrun, 1);

        // Backpressure with data_valid continuously asserted.
        doReset();
        bit_q = '{0, 1, 1, 0};
        exp_d = '{0, 1, 0, 0};
        refreshData();
        for (int k = 0; k < 135; k++) applyStimulus(1'b1, (k * 7) % 300, 1'b1);
        checkOutput("bp_accepts", n_acc, 4);
        checkOutput("bp_sym_count", n_strobe, 4);
        checkOutput("bp_valid_count", n_valid, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpsk_mod.md
Name: dpsk_mod

Overview:
- Modulator stage directly downstream of the `dds` NCO in the DPSK transmitter.
- Accepts serial data bits through a valid/ready handshake and differentially encodes them (d_k = b_k XOR d_{k-1}).
- Multiplies the NCO sine carrier by ±1 per encoded symbol and emits one modulated sample per valid carrier sample.
- Symbol timing is derived by counting valid carrier samples.

Parameters:
- DW, 10, carrier and output sample width (two's complement).
- SPS, 32, carrier samples per symbol; legal range ≥ 2.
- CW, 5, symbol counter width; must satisfy 2^CW ≥ SPS.

Ports:
- clk  in  1  system clock, shared with the NCO.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global enable; 0 freezes all state.
- car_valid  in  1  NCO out_valid.
- car_sin  in  DW  NCO fsin_o, signed.
- data_in  in  1  information bit.
- data_valid  in  1  data_in valid.
- data_ready  out  1  one-entry holding register is empty.
- mod_out  out  DW  modulated sample, signed.
- mod_valid  out  1  mod_out valid.
- sym_strobe  out  1  one-cycle pulse on the first sample of each symbol.
- diff_bit  out  1  encoded symbol currently being transmitted.
- underrun  out  1  sticky flag: symbol boundary reached with no bit held.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and takes priority over clken.
- Reset values:
  - mod_out=0, mod_valid=0, sym_strobe=0, diff_bit=0, underrun=0, data_ready=1.
  - Holding register empty; state IDLE; counter 0; d_prev=0.
- clken=0: no state, counter or register update. mod_valid and sym_strobe are driven 0 that cycle. mod_out, diff_bit and underrun hold.
- Handshake:
  - A bit transfers when data_valid && data_ready && clken.
  - data_ready = !hold_full, registered.
  - It cannot accept and consume in the same cycle. After a consume, data_ready rises the next cycle.
- "Active sample" means car_valid && clken.
- IDLE state:
  - mod_valid=0, mod_out held at 0.
  - On an active sample with hold_full: consume the bit, d = bit XOR d_prev, enter RUN, counter=1, emit the sample with that symbol, sym_strobe=1.
  - An active sample without hold_full is discarded.
- RUN state, on each active sample:
  - If counter < SPS: emit the sample with the current d, then counter++.
  - If counter == SPS (boundary) and hold_full: consume the bit, d = bit XOR d, emit, counter=1, sym_strobe=1.
  - If counter == SPS and the hold is empty: underrun=1 (sticky until reset), go to IDLE, d_prev=0, counter=0, the sample is not emitted.
- Modulation:
  - d=0 → mod_out = car_sin.
  - d=1 → mod_out = −car_sin.
  - −(−2^(DW−1)) saturates to 2^(DW−1)−1 (−512 → +511 at DW=10).
- Latency: mod_out, mod_valid, sym_strobe and diff_bit are registered, 1 cycle after the active sample.
- diff_bit updates in the same cycle as sym_strobe.
- car_valid gaps stall the counter; the symbol length stays at exactly SPS valid samples.
- Reset mid-symbol discards the held bit and the current symbol. No partial output follows reset.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 3 cycles, clken=1, car_valid=1, no data.
  - Required: mod_valid stays 0, data_ready=1, underrun=0.
- Differential encoding:
  - Stimulus: bits 1,0,1,1,0 kept always available, SPS=32.
  - Required: diff_bit sequence 1,1,0,1,1; sym_strobe every 32 mod_valid samples; exactly 160 valid outputs.
- Sign and saturation:
  - Stimulus: car_sin = +300, −300, −512 during a d=1 symbol.
  - Required: mod_out = −300, +300, +511, each 1 cycle later.
- Valid gaps and clken:
  - Stimulus: car_valid toggling 1,0 and clken low for 5 cycles mid-symbol.
  - Required: symbol still spans 32 valid outputs; no output while clken=0; counter resumes.
- Underrun:
  - Stimulus: send one bit, then withhold data past the boundary.
  - Required: underrun=1 at sample 33, mod_valid drops, state IDLE. A later bit 1 restarts with diff_bit=1 (d_prev cleared).
- Handshake backpressure:
  - Stimulus: data_valid held 1 with an incrementing pattern.
  - Required: exactly one acceptance per symbol; data_ready low from accept until the cycle after the boundary consume; no bit lost or duplicated.
